// File: rtl/seq_divider.sv
// Restoring shift/subtract unsigned divider: one quotient bit per clock,
// start/done handshake, divide-by-zero short-circuits straight to DONE.
module seq_divider #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_dvd;
  logic [N-1:0]  r_dvs;
  // Partial remainder never exceeds divisor-1, so only its low N bits are
  // stored; the shifted value and the trial difference carry the extra bit.
  logic [N-1:0]  r_rem;
  logic [N-1:0]  r_q;
  logic [N-1:0]  r_quot;
  logic [N-1:0]  r_rmd;
  logic          r_dbz;

  logic [N:0]    w_shift;
  logic [N:0]    w_trial;
  logic          w_qbit;
  logic [N:0]    w_rem_nxt;
  logic          w_accept;
  logic          w_last;

  assign w_shift   = {r_rem, r_dvd[N-1]};
  assign w_trial   = w_shift - {1'b0, r_dvs};
  assign w_qbit    = ~w_trial[N];
  assign w_rem_nxt = w_qbit ? w_trial : w_shift;
  assign w_accept  = start && (r_state != S_RUN);
  assign w_last    = (r_cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_quot  <= '0;
      r_rmd   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_rem <= w_rem_nxt[N-1:0];
          r_dvd <= {r_dvd[N-2:0], 1'b0};
          r_q   <= {r_q[N-2:0], w_qbit};
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_quot  <= {r_q[N-2:0], w_qbit};
            r_rmd   <= w_rem_nxt[N-1:0];
            r_state <= S_DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request; start is ignored in RUN.
          if (w_accept) begin
            if (divisor == '0) begin
              r_quot  <= '1;
              r_rmd   <= dividend;
              r_dbz   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_dvd   <= dividend;
              r_dvs   <= divisor;
              r_rem   <= '0;
              r_q     <= '0;
              r_cnt   <= '0;
              r_dbz   <= 1'b0;
              r_state <= S_RUN;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign quotient    = r_quot;
  assign remainder   = r_rmd;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (N=4): handshake timing, back-to-back,
// divide-by-zero, ignored start, reset abort and an exhaustive operand sweep.
module tb_seq_divider;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int errors = 0;
  int checks = 0;

  seq_divider #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle; inputs driven here are seen at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== {1'b0, 1'b0, 4'd0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b q=%0d r=%0d dbz=%b, want all zero",
               busy, done, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_basic();
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL basic_busy[%0d]: busy=%b done=%b, want busy=1 done=0", k, busy, done);
      end
      tick();
    end
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== {1'b0, 1'b1, 4'd4, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL basic_done 13/3: busy=%b done=%b q=%0d r=%0d dbz=%b, want 0 1 4 1 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    tick();
    checks++;
    if ({busy, done, quotient, remainder} !== {1'b0, 1'b0, 4'd4, 4'd1}) begin
      errors++;
      $display("FAIL basic_hold: busy=%b done=%b q=%0d r=%0d, want 0 0 4 1",
               busy, done, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back();
    start = 1'b1; dividend = 4'd15; divisor = 4'd1;
    tick();
    dividend = 4'd7; divisor = 4'd9;  // only sampled once DONE accepts
    tick(); tick(); tick(); tick();
    checks++;
    if ({busy, done, quotient, remainder} !== {1'b0, 1'b1, 4'd15, 4'd0}) begin
      errors++;
      $display("FAIL b2b_first 15/1: busy=%b done=%b q=%0d r=%0d, want 0 1 15 0",
               busy, done, quotient, remainder);
    end
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart: busy=%b done=%b, want 1 0", busy, done);
    end
    tick(); tick(); tick(); tick();
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== {1'b0, 1'b1, 4'd0, 4'd7, 1'b0}) begin
      errors++;
      $display("FAIL b2b_second 7/9: busy=%b done=%b q=%0d r=%0d dbz=%b, want 0 1 0 7 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    tick();
  endtask

  task automatic test_div_zero();
    start = 1'b1; dividend = 4'd9; divisor = 4'd0;
    tick();
    start = 1'b0;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== {1'b0, 1'b1, 4'd15, 4'd9, 1'b1}) begin
      errors++;
      $display("FAIL dz_done 9/0: busy=%b done=%b q=%0d r=%0d dbz=%b, want 0 1 15 9 1",
               busy, done, quotient, remainder, div_by_zero);
    end
    tick();
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== {1'b0, 1'b0, 4'd15, 4'd9, 1'b1}) begin
      errors++;
      $display("FAIL dz_hold: busy=%b done=%b q=%0d r=%0d dbz=%b, want 0 0 15 9 1",
               busy, done, quotient, remainder, div_by_zero);
    end
    start = 1'b1; dividend = 4'd8; divisor = 4'd2;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    checks++;
    if ({done, quotient, remainder, div_by_zero} !== {1'b1, 4'd4, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL dz_clear 8/2: done=%b q=%0d r=%0d dbz=%b, want 1 4 0 0",
               done, quotient, remainder, div_by_zero);
    end
    tick();
  endtask

  task automatic test_ignore_start();
    int pulses;
    start = 1'b1; dividend = 4'd12; divisor = 4'd5;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; dividend = 4'd6; divisor = 4'd3;
    tick();
    start = 1'b0;
    tick(); tick();
    checks++;
    if ({done, quotient, remainder} !== {1'b1, 4'd2, 4'd2}) begin
      errors++;
      $display("FAIL ignore_done 12/5: done=%b q=%0d r=%0d, want 1 2 2", done, quotient, remainder);
    end
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0 || quotient !== 4'd2 || remainder !== 4'd2) begin
      errors++;
      $display("FAIL ignore_after: extra activity=%0d q=%0d r=%0d, want 0 2 2", pulses, quotient, remainder);
    end
  endtask

  task automatic test_reset_abort();
    int pulses;
    start = 1'b1; dividend = 4'd14; divisor = 4'd4;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== {1'b0, 1'b0, 4'd0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL abort_reset: busy=%b done=%b q=%0d r=%0d dbz=%b, want all zero",
               busy, done, quotient, remainder, div_by_zero);
    end
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL abort_no_done: done pulses=%0d, want 0", pulses);
    end
  endtask

  task automatic test_sweep();
    int k;
    logic [N-1:0] eq, er;
    logic         ed;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        start = 1'b1; dividend = N'(a); divisor = N'(b);
        tick();
        start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 8) begin
          checks++;
          if (busy === 1'b1 && done === 1'b1) begin
            errors++;
            $display("FAIL sweep_overlap %0d/%0d: busy and done both high", a, b);
          end
          tick();
          k++;
        end
        if (b == 0) begin
          eq = 4'd15; er = N'(a); ed = 1'b1;
        end else begin
          eq = N'(a / b); er = N'(a % b); ed = 1'b0;
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || quotient !== eq || remainder !== er || div_by_zero !== ed) begin
          errors++;
          $display("FAIL sweep %0d/%0d: done=%b busy=%b q=%0d r=%0d dbz=%b, want done=1 busy=0 q=%0d r=%0d dbz=%b",
                   a, b, done, busy, quotient, remainder, div_by_zero, eq, er, ed);
        end
        checks++;
        if (k !== ((b == 0) ? 0 : 4)) begin
          errors++;
          $display("FAIL sweep_latency %0d/%0d: extra cycles=%0d, want %0d", a, b, k, (b == 0) ? 0 : 4);
        end
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_ignore_start();
    test_reset_abort();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
